// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;

  localparam int unsigned KEY_W = 11;

  // Prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard status / housekeeping bytes that never become key events
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  // Event word consumed by core keyboard logic
  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } ps2_key_t;

  // Bit-level receive FSM states
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  // True for bytes that are dropped and reset any pending prefix
  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_BAT)  || (b == PS2_ACK)  || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_OVF0) || (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronisers, clock glitch filter, 11-bit frame FSM, timeout.
module ps2_frame_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned BIT_TIMEOUT = 5000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_c,
  output logic       rx_vld_c,
  output logic       rx_err_c
);
  import ps2_pkg::*;

  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W = $clog2(BIT_TIMEOUT + 1);
  localparam int unsigned BCT_W = 4;

  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic             flt_q, flt_d;
  logic [FLT_W-1:0] fcnt_q, fcnt_d;
  rx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [BCT_W-1:0] bcnt_q, bcnt_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             sample_c;

  // Next-state logic for synchronisers, filter, frame FSM and timeout
  always_comb begin
    clk_s1_d  = ps2_clk_i;
    clk_s2_d  = clk_s1_q;
    dat_s1_d  = ps2_data_i;
    dat_s2_d  = dat_s1_q;
    flt_d     = flt_q;
    fcnt_d    = '0;
    state_d   = state_q;
    shift_d   = shift_q;
    bcnt_d    = bcnt_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    rx_vld_c  = 1'b0;
    rx_err_c  = 1'b0;
    rx_byte_c = shift_q;

    // Accept a new clock level only after FILTER_LEN consecutive differing samples
    if (clk_s2_q != flt_q) begin
      if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
        flt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + FLT_W'(1);
      end
    end
    sample_c = flt_q & ~flt_d;

    if (sample_c) begin
      tmo_d = '0;
    end else if (state_q != RX_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      RX_IDLE: begin
        if (sample_c && !dat_s2_q) begin
          state_d = RX_RECV;
          bcnt_d  = '0;
        end
      end
      RX_RECV: begin
        if (sample_c) begin
          if (bcnt_q == BCT_W'(8)) begin
            par_d   = dat_s2_q;
            state_d = RX_STOP;
          end else begin
            shift_d = {dat_s2_q, shift_q[7:1]};
            bcnt_d  = bcnt_q + BCT_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (sample_c) begin
          state_d = RX_IDLE;
          if (dat_s2_q && (^{par_q, shift_q})) begin
            rx_vld_c = 1'b1;
          end else begin
            rx_err_c = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A sample in the same cycle keeps the frame alive
    if (!sample_c && (state_q != RX_IDLE) && (tmo_q == TMO_W'(BIT_TIMEOUT - 1))) begin
      rx_err_c = 1'b1;
      state_d  = RX_IDLE;
      tmo_d    = '0;
    end
  end

  // Receiver state registers; line idles high so filters preset to 1
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      flt_q    <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= RX_IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
      flt_q    <= flt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to 11-bit ps2_key event word: prefix decoding and output register.
module ps2_key_encoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned BIT_TIMEOUT = 5000,
  parameter int unsigned E1_SKIP     = 7
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        frame_err
);
  import ps2_pkg::*;

  localparam int unsigned SKIP_W = $clog2(E1_SKIP + 1);

  logic [7:0]        rx_byte_c;
  logic              rx_vld_c;
  logic              rx_err_c;

  ps2_key_t          key_q, key_d;
  logic              stb_q, stb_d;
  logic              err_q, err_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .BIT_TIMEOUT(BIT_TIMEOUT)
  ) u_rx (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .rx_byte_c (rx_byte_c),
    .rx_vld_c  (rx_vld_c),
    .rx_err_c  (rx_err_c)
  );

  // Prefix / pause-skip decoder; line errors leave pending prefixes intact
  always_comb begin
    key_d  = key_q;
    stb_d  = 1'b0;
    err_d  = rx_err_c;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;

    if (rx_vld_c) begin
      if (skip_q != '0) begin
        skip_d = skip_q - SKIP_W'(1);
      end else if (rx_byte_c == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte_c == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (rx_byte_c == PS2_PAUSE) begin
        skip_d = SKIP_W'(E1_SKIP);
      end else if (is_discard(rx_byte_c)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        key_d.toggle   = ~key_q.toggle;
        key_d.pressed  = ~brk_q;
        key_d.extended = ext_q;
        key_d.code     = rx_byte_c;
        stb_d          = 1'b1;
        ext_d          = 1'b0;
        brk_d          = 1'b0;
      end
    end
  end

  // Decoder flags and registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_q  <= '0;
      stb_q  <= 1'b0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= '0;
    end else begin
      key_q  <= key_d;
      stb_q  <= stb_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      skip_q <= skip_d;
    end
  end

  assign ps2_key   = key_q;
  assign key_stb   = stb_q;
  assign frame_err = err_q;

endmodule
